// File: rtl/uart_dbg_pkg.sv
// UART debug protocol definitions shared between the host adapter and the remote bridge.
package uart_dbg_pkg;

  typedef enum logic [7:0] {
    CMD_NOP   = 8'h00,
    CMD_READ  = 8'h01,
    CMD_WRITE = 8'h02,
    CMD_RST_A = 8'hFE,
    CMD_RST_D = 8'hFF
  } cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_core.sv
// 8N1/8N2 UART with valid/ready byte interfaces. Bit period is cfg_div+1 clocks.
// Reset is synchronous and active-low.
module uart_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_div,
  input  logic        cfg_txen,
  input  logic        cfg_rxen,
  input  logic        cfg_nstop,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        txd,
  input  logic        rxd
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        tx_busy;
  logic [15:0] tx_tmr;
  logic [3:0]  tx_left;
  logic [9:0]  tx_sh;

  rx_state_t   rx_st;
  logic [1:0]  rxd_sync;
  logic [15:0] rx_tmr;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;

  // A byte is only taken while the shifter is idle; an in-flight byte always finishes.
  assign tx_ready = cfg_txen & ~tx_busy;

  // Transmit shifter: start bit goes out on the accepting edge, then data LSB first, then stop bit(s).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_tmr  <= '0;
      tx_left <= '0;
      tx_sh   <= '1;
      txd     <= 1'b1;
    end else if (!tx_busy) begin
      if (tx_valid && tx_ready) begin
        tx_busy <= 1'b1;
        txd     <= 1'b0;
        tx_sh   <= {2'b11, tx_data};
        tx_left <= cfg_nstop ? 4'd10 : 4'd9;
        tx_tmr  <= cfg_div;
      end
    end else if (tx_tmr != 16'd0) begin
      tx_tmr <= tx_tmr - 16'd1;
    end else if (tx_left == 4'd0) begin
      tx_busy <= 1'b0;
    end else begin
      txd     <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[9:1]};
      tx_left <= tx_left - 4'd1;
      tx_tmr  <= cfg_div;
    end
  end

  // Receiver: synchronise rxd, confirm the start bit at mid-bit, sample each bit at its centre.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_st    <= RX_IDLE;
      rxd_sync <= 2'b11;
      rx_tmr   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (cfg_rxen && !rxd_sync[1]) begin
            rx_st  <= RX_START;
            rx_tmr <= {1'b0, cfg_div[15:1]};
          end
        end
        RX_START: begin
          if (rx_tmr != 16'd0) rx_tmr <= rx_tmr - 16'd1;
          else if (!rxd_sync[1]) begin
            rx_st  <= RX_DATA;
            rx_tmr <= cfg_div;
            rx_bit <= 3'd0;
          end else rx_st <= RX_IDLE;
        end
        RX_DATA: begin
          if (rx_tmr != 16'd0) rx_tmr <= rx_tmr - 16'd1;
          else begin
            rx_sh  <= {rxd_sync[1], rx_sh[7:1]};
            rx_tmr <= cfg_div;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tmr != 16'd0) rx_tmr <= rx_tmr - 16'd1;
          else begin
            rx_st <= RX_IDLE;
            if (rxd_sync[1]) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
            end
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb2uart_host.sv
// Wishbone pipelined responder that turns each bus access into a UART debug frame
// and returns the remote read reply; also issues remote reset assert/de-assert commands.
//
//  state  | meaning
//  IDLE   | waiting for a bus request or a remote reset request
//  RST    | sending the remote reset command byte
//  CMD    | sending the read/write command byte
//  ADDR   | sending address bytes, LSB first
//  DATA   | sending write data bytes, LSB first
//  RDWAIT | collecting read reply bytes, timeout running
//  RESP   | one-cycle ack/err on the bus
module wb2uart_host
  import uart_dbg_pkg::*;
#(
  parameter int ADDR_BYTE = 2,
  parameter int DATA_BYTE = 2,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 100,
  parameter int TIMEOUT   = 2000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   uart_txd,
  input  logic                   uart_rxd,
  input  logic                   rst_valid,
  input  logic                   rst_assert,
  output logic                   rst_ready,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [8*ADDR_BYTE-1:0] wb_adr_i,
  input  logic [8*DATA_BYTE-1:0] wb_dat_i,
  output logic [8*DATA_BYTE-1:0] wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_stall_o
);

  localparam int AW  = 8 * ADDR_BYTE;
  localparam int DW  = 8 * DATA_BYTE;
  localparam int BCW = $clog2(max_int(ADDR_BYTE, DATA_BYTE) + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int DIV = CLK_FREQ * 1000000 / BAUD_RATE - 1;
  localparam logic [15:0] CFG_DIV = DIV[15:0];
  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTE - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTE - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TO_MAX    = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_CMD, S_ADDR, S_DATA, S_RDWAIT, S_RESP} state_t;

  state_t                     state;
  logic [AW-1:0]              adr_q;
  logic [DW-1:0]              dat_q;
  logic                       we_q;
  cmd_t                       rst_cmd_q;
  logic [BCW-1:0]             byte_idx;
  logic [TW-1:0]              to_cnt;
  logic [DATA_BYTE-1:0][7:0]  rd_bytes;
  logic [DATA_BYTE-1:0][7:0]  rd_next;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_hs;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] adr_byte;
  logic [7:0] dat_byte;

  assign wb_stall_o = (state != S_IDLE);
  assign tx_hs      = tx_valid & tx_ready;

  // Byte select over the latched address/data, and the outgoing byte for the current state.
  always_comb begin
    adr_byte = 8'h00;
    dat_byte = 8'h00;
    for (int i = 0; i < ADDR_BYTE; i++)
      if (byte_idx == BCW'(i)) adr_byte = adr_q[8*i +: 8];
    for (int i = 0; i < DATA_BYTE; i++)
      if (byte_idx == BCW'(i)) dat_byte = dat_q[8*i +: 8];
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_RST:  begin tx_valid = 1'b1; tx_data = rst_cmd_q; end
      S_CMD:  begin tx_valid = 1'b1; tx_data = we_q ? CMD_WRITE : CMD_READ; end
      S_ADDR: begin tx_valid = 1'b1; tx_data = adr_byte; end
      S_DATA: begin tx_valid = 1'b1; tx_data = dat_byte; end
      default: ;
    endcase
  end

  // Read word with the incoming byte placed at the current byte position (LSB first).
  always_comb begin
    rd_next = rd_bytes;
    for (int i = 0; i < DATA_BYTE; i++)
      if (byte_idx == BCW'(i)) rd_next[i] = rx_data;
  end

  // Sequencing FSM; ack/err/rst_ready are registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      rst_cmd_q <= CMD_RST_D;
      byte_idx  <= '0;
      to_cnt    <= '0;
      rd_bytes  <= '0;
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      rst_ready <= 1'b0;
    end else begin
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      rst_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i && !wb_stall_o) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            we_q  <= wb_we_i;
            state <= S_CMD;
          end else if (rst_valid) begin
            rst_cmd_q <= rst_assert ? CMD_RST_A : CMD_RST_D;
            state     <= S_RST;
          end
        end
        S_RST: begin
          if (tx_hs) begin
            rst_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_CMD: begin
          if (tx_hs) begin
            byte_idx <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (tx_hs) begin
            if (byte_idx == ADDR_LAST) begin
              byte_idx <= '0;
              if (we_q) state <= S_DATA;
              else begin
                to_cnt <= '0;
                state  <= S_RDWAIT;
              end
            end else byte_idx <= byte_idx + BCW'(1);
          end
        end
        S_DATA: begin
          if (tx_hs) begin
            if (byte_idx == DATA_LAST) begin
              wb_ack_o <= wb_cyc_i;
              state    <= S_RESP;
            end else byte_idx <= byte_idx + BCW'(1);
          end
        end
        S_RDWAIT: begin
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
          if (rx_valid) begin
            rd_bytes <= rd_next;
            if (byte_idx == DATA_LAST) begin
              wb_dat_o <= rd_next;
              wb_ack_o <= wb_cyc_i;
              state    <= S_RESP;
            end else byte_idx <= byte_idx + BCW'(1);
          end else if (to_cnt == TO_LAST) begin
            wb_dat_o <= '1;
            wb_err_o <= wb_cyc_i;
            state    <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Replies are consumed every cycle; anything arriving outside RDWAIT is simply dropped.
  uart_core u_uart (
    .clk       (clk),
    .rst_n     (~rst),
    .cfg_div   (CFG_DIV),
    .cfg_txen  (enable),
    .cfg_rxen  (enable),
    .cfg_nstop (1'b0),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (1'b1),
    .rx_data   (rx_data),
    .txd       (uart_txd),
    .rxd       (uart_rxd)
  );

endmodule

// File: tb/tb_wb2uart_host.sv
// Bench for wb2uart_host: a UART BFM plays the remote bridge, scoreboards hold the
// expected line bytes and expected bus responses.
module tb_wb2uart_host;

  localparam int P       = 10;
  localparam int TIMEOUT = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;
  logic        rst_valid = 1'b0;
  logic        rst_assert = 1'b0;
  logic        rst_ready;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [15:0] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_stall_o;

  wb2uart_host #(
    .ADDR_BYTE(2), .DATA_BYTE(2), .BAUD_RATE(1000000), .CLK_FREQ(10), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .rst_valid(rst_valid), .rst_assert(rst_assert), .rst_ready(rst_ready),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_stall_o(wb_stall_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        reply;
    logic        drop_cyc;
    logic        exp_err;
    logic [15:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [15:0] dat;
  } resp_t;

  logic [7:0] exp_line_q[$];
  resp_t      exp_resp_q[$];

  // Line decoder (remote side): sample each bit at its centre, compare against the expected bytes.
  int         line_cnt = 0;
  int         last_byte_start = 0;
  logic       ln_busy = 1'b0;
  int         ln_start = 0;
  int         ln_n, ln_k;
  logic [7:0] ln_sh = '0;
  always @(negedge clk) begin
    if (rst) ln_busy = 1'b0;
    else if (!ln_busy) begin
      if (uart_txd == 1'b0) begin
        ln_busy  = 1'b1;
        ln_start = cyc;
      end
    end else begin
      ln_n = cyc - ln_start;
      if (ln_n % P == P / 2) begin
        ln_k = ln_n / P;
        if (ln_k >= 1 && ln_k <= 8) ln_sh[ln_k-1] = uart_txd;
        else if (ln_k == 9) begin
          ln_busy = 1'b0;
          line_cnt++;
          last_byte_start = ln_start;
          check("line_stop_bit", {31'd0, uart_txd}, 32'd1);
          if (exp_line_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL line_byte: got %h, no byte expected", ln_sh);
          end else check("line_byte", {24'd0, ln_sh}, {24'd0, exp_line_q.pop_front()});
        end
      end
    end
  end

  // Bus response monitor.
  int    resp_cnt = 0;
  int    last_resp_cyc = 0;
  resp_t r_mon;
  always @(negedge clk) begin
    if (!rst && (wb_ack_o || wb_err_o)) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      if (exp_resp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b dat=%h, none expected", wb_ack_o, wb_err_o, wb_dat_o);
      end else begin
        r_mon = exp_resp_q.pop_front();
        check("resp_err", {31'd0, wb_err_o}, {31'd0, r_mon.err});
        check("resp_ack", {31'd0, wb_ack_o}, {31'd0, ~r_mon.err});
        if (r_mon.chk_dat) check("resp_dat", {16'd0, wb_dat_o}, {16'd0, r_mon.dat});
      end
    end
  end

  int rr_cnt = 0;
  always @(negedge clk) if (!rst && rst_ready) rr_cnt++;

  task automatic uart_send(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (P) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (P) @(negedge clk);
  endtask

  task automatic wait_line(input int target, input string name);
    int n = 0;
    while (line_cnt < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_line_bytes"}, line_cnt, target);
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_cnt < target && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_resp_count"}, resp_cnt, target);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (wb_stall_o && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, wb_stall_o}, 32'd0);
  endtask

  task automatic wb_issue(input vec_t v);
    int n = 0;
    while (wb_stall_o && n < 8000) begin
      @(negedge clk);
      n++;
    end
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = v.we;
    wb_adr_i = v.adr;
    wb_dat_i = v.dat;
    @(negedge clk);
    wb_stb_i = 1'b0;
    check("stall_after_accept", {31'd0, wb_stall_o}, 32'd1);
    if (v.drop_cyc) wb_cyc_i = 1'b0;
  endtask

  task automatic push_frame(input vec_t v);
    resp_t r;
    exp_line_q.push_back(v.we ? 8'h02 : 8'h01);
    exp_line_q.push_back(v.adr[7:0]);
    exp_line_q.push_back(v.adr[15:8]);
    if (v.we) begin
      exp_line_q.push_back(v.dat[7:0]);
      exp_line_q.push_back(v.dat[15:8]);
    end
    if (!v.drop_cyc) begin
      r.err     = v.exp_err;
      r.chk_dat = ~v.we;
      r.dat     = v.exp_err ? 16'hFFFF : v.exp_dat;
      exp_resp_q.push_back(r);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int base_line, base_resp;
    base_line = line_cnt;
    base_resp = resp_cnt;
    push_frame(v);
    wb_issue(v);
    wait_line(base_line + (v.we ? 5 : 3), name);
    if (!v.we && v.reply) begin
      uart_send(v.exp_dat[7:0]);
      uart_send(v.exp_dat[15:8]);
    end
    if (v.drop_cyc) begin
      wait_idle(name);
      repeat (5) @(negedge clk);
      check({name, "_no_resp"}, resp_cnt, base_resp);
    end else begin
      wait_resp(base_resp + 1, name);
      wait_idle(name);
      wb_cyc_i = 1'b0;
      if (v.we) check({name, "_ack_at_last_byte"}, last_resp_cyc, last_byte_start);
      if (v.exp_err) check({name, "_err_latency"}, last_resp_cyc - last_byte_start, TIMEOUT);
    end
    repeat (5) @(negedge clk);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    int n, base_line, base_resp, base_rr;
    //         we    adr       dat       reply drop  err   exp_dat
    vecs[0] = '{1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h00A5, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hABCD};
    vecs[2] = '{1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1357};
    vecs[5] = '{1'b1, 16'h00FF, 16'hA55A, 1'b0, 1'b1, 1'b0, 16'h0000};

    repeat (4) @(negedge clk);
    check("reset_ack", {31'd0, wb_ack_o}, 32'd0);
    check("reset_err", {31'd0, wb_err_o}, 32'd0);
    check("reset_rst_ready", {31'd0, rst_ready}, 32'd0);
    check("reset_dat", {16'd0, wb_dat_o}, 32'd0);
    check("reset_txd", {31'd0, uart_txd}, 32'd1);
    check("reset_stall", {31'd0, wb_stall_o}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Write request and reset request in the same cycle: write frame first, then FE.
    base_line = line_cnt;
    base_resp = resp_cnt;
    base_rr   = rr_cnt;
    v = '{1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000};
    push_frame(v);
    exp_line_q.push_back(8'hFE);
    rst_valid  = 1'b1;
    rst_assert = 1'b1;
    wb_issue(v);
    n = 0;
    while (!rst_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rst_ready_seen", {31'd0, rst_ready}, 32'd1);
    rst_valid = 1'b0;
    wait_line(base_line + 6, "wr_then_rst");
    wait_resp(base_resp + 1, "wr_then_rst");
    wb_cyc_i = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_ready_pulses", rr_cnt - base_rr, 1);

    // Stand-alone de-assert command.
    base_line = line_cnt;
    base_rr   = rr_cnt;
    exp_line_q.push_back(8'hFF);
    rst_valid  = 1'b1;
    rst_assert = 1'b0;
    n = 0;
    while (!rst_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rst_d_ready_seen", {31'd0, rst_ready}, 32'd1);
    rst_valid = 1'b0;
    wait_line(base_line + 1, "rst_d");
    repeat (20) @(negedge clk);
    check("rst_d_pulses", rr_cnt - base_rr, 1);

    // Reset during the address byte of a read: abandon frame, no response.
    base_line = line_cnt;
    base_resp = resp_cnt;
    exp_line_q.push_back(8'h01);
    v = '{1'b0, 16'h3C96, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    wb_issue(v);
    wait_line(base_line + 1, "abort");
    n = 0;
    while (!ln_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_addr_started", {31'd0, ln_busy}, 32'd1);
    repeat (3 * P) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", {31'd0, wb_stall_o}, 32'd0);
    check("abort_txd_high", {31'd0, uart_txd}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wb_cyc_i = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_resp", resp_cnt, base_resp);
    check("abort_line_bytes", line_cnt, base_line + 1);
    check("abort_txd_idle", {31'd0, uart_txd}, 32'd1);
    v = '{1'b0, 16'h3C96, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h2468};
    run_vec(v, "after_abort");

    // Stray byte while idle must not leak into the next read.
    uart_send(8'h5A);
    repeat (20) @(negedge clk);
    v = '{1'b0, 16'h0077, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hC0DE};
    run_vec(v, "after_stray");

    // Transmit disabled: request is held, nothing goes out until enable returns.
    base_line = line_cnt;
    base_resp = resp_cnt;
    enable = 1'b0;
    v = '{1'b1, 16'h5555, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0000};
    push_frame(v);
    wb_issue(v);
    repeat (300) @(negedge clk);
    check("disabled_no_tx", line_cnt, base_line);
    check("disabled_stall", {31'd0, wb_stall_o}, 32'd1);
    enable = 1'b1;
    wait_line(base_line + 5, "enable_resume");
    wait_resp(base_resp + 1, "enable_resume");
    wait_idle("enable_resume");
    wb_cyc_i = 1'b0;
    repeat (20) @(negedge clk);

    check("line_q_drained", exp_line_q.size(), 0);
    check("resp_q_drained", exp_resp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
